// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types, grant encoding and strobe decode for sram_port_arbiter
package sram_arb_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 18;
   localparam int LADDR_W    = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD1,
      ST_RD2,
      ST_WR1,
      ST_WR2,
      ST_WR3,
      ST_DONE
   } state_t;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_DM = 1'b1
   } gnt_t;

   typedef struct packed {
      logic en;
      logic oe;
      logic we;
      logic doe;
   } strobe_t;

   localparam strobe_t STROBE_IDLE = '{en: 1'b1, oe: 1'b1, we: 1'b1, doe: 1'b0};

   // Pin strobes (active-low en/oe/we) for the state about to be entered.
   function automatic strobe_t strobes_for(state_t s);
      strobe_t r;
      r = STROBE_IDLE;
      case (s)
         ST_RD1, ST_RD2: begin
            r.en = 1'b0;
            r.oe = 1'b0;
         end
         ST_WR1, ST_WR3: begin
            r.en  = 1'b0;
            r.doe = 1'b1;
         end
         ST_WR2: begin
            r.en  = 1'b0;
            r.we  = 1'b0;
            r.doe = 1'b1;
         end
         default: r = STROBE_IDLE;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - fetch/data request ports and SRAM pin bundle
interface sram_port_arbiter_if
   import sram_arb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);
   logic               if_req;
   logic [LADDR_W-1:0] if_addr;
   logic               if_ack;
   logic [DATA_W-1:0]  if_rdata;

   logic               dm_req;
   logic               dm_we;
   logic [LADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0]  dm_wdata;
   logic               dm_ack;
   logic [DATA_W-1:0]  dm_rdata;

   logic               stall;

   logic               ram_en;
   logic               ram_oe;
   logic               ram_we;
   logic [ADDR_W-1:0]  ram_addr;
   logic [DATA_W-1:0]  ram_dout;
   logic               ram_doe;
   logic [DATA_W-1:0]  ram_din;

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_din,
      input  if_ack, if_rdata, dm_ack, dm_rdata, stall,
      input  ram_en, ram_oe, ram_we, ram_addr, ram_dout, ram_doe
   );

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_din,
      output if_ack, if_rdata, dm_ack, dm_rdata, stall,
      output ram_en, ram_oe, ram_we, ram_addr, ram_dout, ram_doe
   );

endinterface

// File: rtl/sram_arb_grant.sv
// rtl/sram_arb_grant.sv - grant pick; SRAM_ARB_RR_EN adds round-robin last-grant pointer
module sram_arb_grant
   import sram_arb_pkg::*;
(
`ifdef SRAM_ARB_RR_EN
   input  logic clk,
   input  logic rst_n,
   input  logic take,
`endif
   input  logic if_req,
   input  logic dm_req,
   output gnt_t gnt,
   output logic any
);

   assign any = if_req | dm_req;

`ifdef SRAM_ARB_RR_EN
   gnt_t last_q;
   gnt_t last_d;

   always_comb begin
      last_d = last_q;
      if (take) last_d = gnt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_q <= GNT_IF;
      else        last_q <= last_d;
   end

   // On contention the port that did not win last time gets the port.
   always_comb begin
      gnt = dm_req ? GNT_DM : GNT_IF;
      if (if_req && dm_req) gnt = (last_q == GNT_DM) ? GNT_IF : GNT_DM;
   end
`else
   // Data wins: it belongs to the older instruction in the pipeline.
   always_comb begin
      gnt = dm_req ? GNT_DM : GNT_IF;
   end
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shared async SRAM port for IF/MEM stages; SRAM_ARB_RR_EN selects round-robin grant
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
)(
   input logic               CLK,
   input logic               RST,
   sram_port_arbiter_if.slave bus
);

   state_t              state_q, state_d;
   gnt_t                gnt_q, gnt_d;
   gnt_t                pick;
   logic                any;
   logic                take;
   logic                req_we;
   logic [LADDR_W-1:0]  req_addr;

   strobe_t             strb_q, strb_d;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]   ram_dout_q, ram_dout_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
   logic                if_ack_q, if_ack_d;
   logic                dm_ack_q, dm_ack_d;

   sram_arb_grant u_grant (
`ifdef SRAM_ARB_RR_EN
      .clk    (CLK),
      .rst_n  (RST),
      .take   (take),
`endif
      .if_req (bus.if_req),
      .dm_req (bus.dm_req),
      .gnt    (pick),
      .any    (any)
   );

   assign take     = (state_q == ST_IDLE) && any;
   assign req_we   = (pick == GNT_DM) && bus.dm_we;
   assign req_addr = (pick == GNT_DM) ? bus.dm_addr : bus.if_addr;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= ST_IDLE;
         gnt_q      <= GNT_IF;
         strb_q     <= STROBE_IDLE;
         ram_addr_q <= '0;
         ram_dout_q <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
         if_ack_q   <= 1'b0;
         dm_ack_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         strb_q     <= strb_d;
         ram_addr_q <= ram_addr_d;
         ram_dout_q <= ram_dout_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
         if_ack_q   <= if_ack_d;
         dm_ack_q   <= dm_ack_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (any) state_d = req_we ? ST_WR1 : ST_RD1;
         ST_RD1:  state_d = ST_RD2;
         ST_RD2:  state_d = ST_DONE;
         ST_WR1:  state_d = ST_WR2;
         ST_WR2:  state_d = ST_WR3;
         ST_WR3:  state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Strobes and acks are decoded from the next state so the pins come straight off flops.
   always_comb begin
      strb_d     = strobes_for(state_d);
      gnt_d      = take ? pick : gnt_q;
      ram_addr_d = take ? ADDR_W'(req_addr) : ram_addr_q;
      ram_dout_d = (take && req_we) ? bus.dm_wdata : ram_dout_q;
      if_ack_d   = (state_d == ST_DONE) && (gnt_d == GNT_IF);
      dm_ack_d   = (state_d == ST_DONE) && (gnt_d == GNT_DM);
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      if (state_q == ST_RD2) begin
         if (gnt_q == GNT_DM) dm_rdata_d = bus.ram_din;
         else                 if_rdata_d = bus.ram_din;
      end
   end

   assign bus.if_ack   = if_ack_q;
   assign bus.dm_ack   = dm_ack_q;
   assign bus.if_rdata = if_rdata_q;
   assign bus.dm_rdata = dm_rdata_q;
   assign bus.ram_en   = strb_q.en;
   assign bus.ram_oe   = strb_q.oe;
   assign bus.ram_we   = strb_q.we;
   assign bus.ram_doe  = strb_q.doe;
   assign bus.ram_addr = ram_addr_q;
   assign bus.ram_dout = ram_dout_q;
   assign bus.stall    = (bus.if_req & ~if_ack_q) | (bus.dm_req & ~dm_ack_q);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - scoreboard bench for sram_port_arbiter
module tb_sram_port_arbiter;
   import sram_arb_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sram_port_arbiter_if bus ();

   sram_port_arbiter dut (
      .CLK (clk),
      .RST (rst_n),
      .bus (bus)
   );

   typedef struct {
      bit          dm;
      bit          we;
      logic [17:0] addr;
      logic [15:0] data;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] mem [logic [17:0]];
   int          n_en, n_oe, n_we, n_doe;
   logic [17:0] seen_addr;
   logic [15:0] seen_dout;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic push(input bit dm, input bit we, input logic [15:0] addr, input logic [15:0] data);
      exp_t e;
      e.dm = dm; e.we = we; e.addr = {2'b00, addr}; e.data = data;
      sb.push_back(e);
   endtask

   // SRAM model, per-access strobe counters and scoreboard checks on every ack.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         n_en = 0; n_oe = 0; n_we = 0; n_doe = 0;
         bus.ram_din = 16'h0000;
      end else begin
         chk("oe_we_both_low", {31'd0, (!bus.ram_oe && !bus.ram_we)}, 32'd0);
         chk("doe_with_oe", {31'd0, (bus.ram_doe && !bus.ram_oe)}, 32'd0);
         chk("stall", {31'd0, bus.stall},
             {31'd0, (bus.if_req & ~bus.if_ack) | (bus.dm_req & ~bus.dm_ack)});
         if (!bus.ram_en) begin
            n_en++;
            seen_addr = bus.ram_addr;
            if (!bus.ram_oe) begin
               n_oe++;
               bus.ram_din = mem.exists(bus.ram_addr) ? mem[bus.ram_addr] : 16'hDEAD;
            end
            if (!bus.ram_we) begin
               n_we++;
               if (bus.ram_doe) mem[bus.ram_addr] = bus.ram_dout;
            end
            if (bus.ram_doe) begin
               n_doe++;
               seen_dout = bus.ram_dout;
            end
         end
         if (bus.if_ack || bus.dm_ack) begin
            chk("both_ack", {31'd0, bus.if_ack & bus.dm_ack}, 32'd0);
            if (sb.size() == 0) begin
               chk("sb_empty_on_ack", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("ack_port", {31'd0, bus.dm_ack}, {31'd0, e.dm});
               chk("ram_addr", {14'd0, seen_addr}, {14'd0, e.addr});
               if (e.we) begin
                  chk("wr_dout", {16'd0, seen_dout}, {16'd0, e.data});
                  chk("wr_en_cycles", n_en, 3);
                  chk("wr_we_cycles", n_we, 1);
                  chk("wr_doe_cycles", n_doe, 3);
                  chk("wr_oe_cycles", n_oe, 0);
               end else begin
                  chk("rdata", {16'd0, e.dm ? bus.dm_rdata : bus.if_rdata}, {16'd0, e.data});
                  chk("rd_en_cycles", n_en, 2);
                  chk("rd_oe_cycles", n_oe, 2);
                  chk("rd_we_cycles", n_we, 0);
                  chk("rd_doe_cycles", n_doe, 0);
               end
            end
            n_en = 0; n_oe = 0; n_we = 0; n_doe = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Raises the selected requests, drops each on its ack; latencies are edges from raise to ack.
   task automatic run(input bit use_if, input logic [15:0] ia,
                      input bit use_dm, input bit dwe, input logic [15:0] da, input logic [15:0] dw,
                      output int if_lat, output int dm_lat);
      int start;
      bit if_done, dm_done;
      if_done = !use_if; dm_done = !use_dm;
      if_lat = -1; dm_lat = -1;
      bus.if_req = use_if; bus.if_addr = ia;
      bus.dm_req = use_dm; bus.dm_we = dwe; bus.dm_addr = da; bus.dm_wdata = dw;
      start = cyc;
      for (int i = 0; i < 40 && !(if_done && dm_done); i++) begin
         step();
         if (bus.if_ack && !if_done) begin
            if_done = 1; if_lat = cyc - start; bus.if_req = 1'b0;
         end
         if (bus.dm_ack && !dm_done) begin
            dm_done = 1; dm_lat = cyc - start; bus.dm_req = 1'b0;
         end
      end
      chk("run_timeout", {30'd0, if_done, dm_done}, 32'd3);
      bus.if_req = 1'b0; bus.dm_req = 1'b0;
      step();
   endtask

   initial begin
      int il, dl, a1, a2, dm_n, if_n, ord_v;
      rst_n = 1'b0;
      bus.if_req = 0; bus.if_addr = 0; bus.dm_req = 0; bus.dm_we = 0;
      bus.dm_addr = 0; bus.dm_wdata = 0;
      mem[18'h00010] = 16'h4A21;
      mem[18'h00011] = 16'h5B32;
      mem[18'h00030] = 16'hC0DE;
      repeat (3) step();
      chk("rst_en", {31'd0, bus.ram_en}, 32'd1);
      chk("rst_oe", {31'd0, bus.ram_oe}, 32'd1);
      chk("rst_we", {31'd0, bus.ram_we}, 32'd1);
      chk("rst_doe", {31'd0, bus.ram_doe}, 32'd0);
      chk("rst_addr", {14'd0, bus.ram_addr}, 32'd0);
      chk("rst_dout", {16'd0, bus.ram_dout}, 32'd0);
      chk("rst_acks", {30'd0, bus.if_ack, bus.dm_ack}, 32'd0);
      chk("rst_rdata", {bus.if_rdata, bus.dm_rdata}, 32'd0);
      rst_n = 1'b1;
      step();

      // Fetch read
      push(0, 0, 16'h0010, 16'h4A21);
      run(1, 16'h0010, 0, 0, 16'h0, 16'h0, il, dl);
      chk("fetch_latency", il, 3);
      chk("stall_idle", {31'd0, bus.stall}, 32'd0);

      // Data write then read-back
      push(1, 1, 16'hBF00, 16'h1234);
      run(0, 16'h0, 1, 1, 16'hBF00, 16'h1234, il, dl);
      chk("write_latency", dl, 4);
      push(1, 0, 16'hBF00, 16'h1234);
      run(0, 16'h0, 1, 0, 16'hBF00, 16'h0, il, dl);
      chk("readback_latency", dl, 3);
      chk("if_rdata_hold", {16'd0, bus.if_rdata}, 32'h4A21);

      // Simultaneous fetch and data read
`ifdef SRAM_ARB_RR_EN
      push(0, 0, 16'h0011, 16'h5B32);
      push(1, 0, 16'h0030, 16'hC0DE);
      run(1, 16'h0011, 1, 0, 16'h0030, 16'h0, il, dl);
      chk("contend_first", il, 3);
      chk("contend_gap", dl - il, 4);
`else
      push(1, 0, 16'h0030, 16'hC0DE);
      push(0, 0, 16'h0011, 16'h5B32);
      run(1, 16'h0011, 1, 0, 16'h0030, 16'h0, il, dl);
      chk("contend_first", dl, 3);
      chk("contend_gap", il - dl, 4);
`endif

      // Back-to-back fetch with address change on the first ack
      push(0, 0, 16'h0010, 16'h4A21);
      push(0, 0, 16'h0011, 16'h5B32);
      bus.if_req = 1'b1; bus.if_addr = 16'h0010;
      a1 = -1; a2 = -1; il = cyc;
      for (int i = 0; i < 30 && a2 < 0; i++) begin
         step();
         if (bus.if_ack) begin
            if (a1 < 0) begin a1 = cyc - il; bus.if_addr = 16'h0011; end
            else begin a2 = cyc - il; bus.if_req = 1'b0; end
         end
      end
      bus.if_req = 1'b0;
      chk("b2b_first", a1, 3);
      chk("b2b_gap", a2 - a1, 4);
      step();

      // Reset asserted during WR2
      push(1, 1, 16'h0020, 16'h5555);
      bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 16'h0020; bus.dm_wdata = 16'h5555;
      for (int i = 0; i < 10; i++) begin
         step();
         if (!bus.ram_we) break;
      end
      chk("reach_wr2", {31'd0, bus.ram_we}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_we", {31'd0, bus.ram_we}, 32'd1);
      chk("rst_mid_en", {31'd0, bus.ram_en}, 32'd1);
      chk("rst_mid_oe", {31'd0, bus.ram_oe}, 32'd1);
      chk("rst_mid_doe", {31'd0, bus.ram_doe}, 32'd0);
      step();
      step();
      chk("rst_mid_noack", {31'd0, bus.dm_ack}, 32'd0);
      #2 rst_n = 1'b1;
      step();
      chk("restart_wr1_en", {31'd0, bus.ram_en}, 32'd0);
      chk("restart_wr1_we", {31'd0, bus.ram_we}, 32'd1);
      chk("restart_wr1_doe", {31'd0, bus.ram_doe}, 32'd1);
      a1 = -1;
      for (int i = 0; i < 10 && a1 < 0; i++) begin
         step();
         if (bus.dm_ack) begin a1 = i; bus.dm_req = 1'b0; end
      end
      bus.dm_req = 1'b0;
      chk("restart_ack_edges", a1, 2);
      step();

      // Single fetch leaves the last grant on fetch before repeated contention
      push(0, 0, 16'h0011, 16'h5B32);
      run(1, 16'h0011, 0, 0, 16'h0, 16'h0, il, dl);

      // Repeated contention: both held, each port served twice
`ifdef SRAM_ARB_RR_EN
      push(1, 0, 16'h0030, 16'hC0DE);
      push(0, 0, 16'h0010, 16'h4A21);
      push(1, 0, 16'h0030, 16'hC0DE);
      push(0, 0, 16'h0010, 16'h4A21);
`else
      push(1, 0, 16'h0030, 16'hC0DE);
      push(1, 0, 16'h0030, 16'hC0DE);
      push(0, 0, 16'h0010, 16'h4A21);
      push(0, 0, 16'h0010, 16'h4A21);
`endif
      bus.if_req = 1'b1; bus.if_addr = 16'h0010;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 16'h0030;
      dm_n = 0; if_n = 0; ord_v = 0;
      for (int i = 0; i < 60 && (dm_n + if_n) < 4; i++) begin
         step();
         if (bus.dm_ack) begin
            dm_n++; ord_v = (ord_v << 1) | 1;
            if (dm_n == 2) bus.dm_req = 1'b0;
         end
         if (bus.if_ack) begin
            if_n++; ord_v = ord_v << 1;
            if (if_n == 2) bus.if_req = 1'b0;
         end
      end
      bus.if_req = 1'b0; bus.dm_req = 1'b0;
      chk("repeat_count", dm_n + if_n, 4);
`ifdef SRAM_ARB_RR_EN
      chk("repeat_order", ord_v, 32'b1010);
`else
      chk("repeat_order", ord_v, 32'b1100);
`endif
      step();
      step();
      chk("sb_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
